// File: rtl/se_pkg.sv
// Constants shared between the update scatter serializer and the gather side.
package se_pkg;
    localparam int UPDATE_W   = 64;
    localparam int SE_LANES   = 8;
    localparam int LANE_IDX_W = $clog2(SE_LANES);
    localparam int CNT_W      = $clog2(SE_LANES + 1);
endpackage

// File: rtl/gather_idle_timer.sv
// Idle counter for a partially filled gather group; expired pulses on the cycle
// the count would reach TIMEOUT so the flush lands on that same edge.
module gather_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);
    logic [7:0] r_count;

    assign expired = run && !clear && (r_count == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || expired) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + 8'd1;
        end
    end
endmodule

// File: rtl/update_gather.sv
// Packs the serial update stream back into SE_LANES-wide groups; partial groups
// leave on flush or idle timeout, full groups leave with no bubble.
module update_gather
    import se_pkg::*;
#(
    parameter int WIDTH   = UPDATE_W,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_word,
    input  logic             input_valid,
    input  logic             flush,
    input  logic             downstream_stall,
    output logic [WIDTH-1:0] output_update0,
    output logic [WIDTH-1:0] output_update1,
    output logic [WIDTH-1:0] output_update2,
    output logic [WIDTH-1:0] output_update3,
    output logic [WIDTH-1:0] output_update4,
    output logic [WIDTH-1:0] output_update5,
    output logic [WIDTH-1:0] output_update6,
    output logic [WIDTH-1:0] output_update7,
    output logic             output_valid0,
    output logic             output_valid1,
    output logic             output_valid2,
    output logic             output_valid3,
    output logic             output_valid4,
    output logic             output_valid5,
    output logic             output_valid6,
    output logic             output_valid7,
    output logic             gather_stall_request
);
    logic [WIDTH-1:0]    r_buf        [SE_LANES];
    logic [WIDTH-1:0]    r_out_update [SE_LANES];
    logic [SE_LANES-1:0] r_out_valid;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_flush_pend;

    logic w_closing;
    logic w_emit;
    logic w_accept;
    logic w_expired;
    logic w_timer_run;
    logic w_timer_clear;

    // A group is closing once it is full or a flush/timeout has been latched.
    assign w_closing            = (r_cnt == CNT_W'(SE_LANES)) || r_flush_pend;
    assign gather_stall_request = w_closing && downstream_stall;
    assign w_emit               = w_closing && (r_cnt != '0) && !downstream_stall;
    assign w_accept             = input_valid && !gather_stall_request;
    assign w_timer_run          = (r_cnt != '0) && !w_accept && !r_flush_pend;
    assign w_timer_clear        = w_accept || w_emit;

    gather_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (w_timer_run),
        .clear   (w_timer_clear),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= '0;
            for (int i = 0; i < SE_LANES; i++) begin
                r_out_update[i] <= '0;
            end
        end else if (w_emit) begin
            for (int i = 0; i < SE_LANES; i++) begin
                r_out_update[i] <= r_buf[i];
                r_out_valid[i]  <= (CNT_W'(i) < r_cnt);
            end
            // The word taken during the emit opens the next group in lane 0.
            if (w_accept) begin
                r_buf[0] <= input_word;
                r_cnt    <= CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            r_flush_pend <= flush && w_accept && !r_flush_pend;
        end else begin
            r_out_valid <= '0;
            if (w_accept) begin
                r_buf[r_cnt[LANE_IDX_W-1:0]] <= input_word;
                r_cnt                        <= r_cnt + CNT_W'(1);
            end
            if ((flush && ((r_cnt != '0) || w_accept)) || w_expired) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign output_update0 = r_out_update[0];
    assign output_update1 = r_out_update[1];
    assign output_update2 = r_out_update[2];
    assign output_update3 = r_out_update[3];
    assign output_update4 = r_out_update[4];
    assign output_update5 = r_out_update[5];
    assign output_update6 = r_out_update[6];
    assign output_update7 = r_out_update[7];
    assign output_valid0  = r_out_valid[0];
    assign output_valid1  = r_out_valid[1];
    assign output_valid2  = r_out_valid[2];
    assign output_valid3  = r_out_valid[3];
    assign output_valid4  = r_out_valid[4];
    assign output_valid5  = r_out_valid[5];
    assign output_valid6  = r_out_valid[6];
    assign output_valid7  = r_out_valid[7];
endmodule

// File: doc/update_gather.md
# update_gather

Gathers the serial update stream, one 64-bit update per cycle, back into 8-lane parallel groups. It is the inverse of the scatter-side serializer: a group emitted here and fed to the 8-lane serializer comes back out in the same order. It sits between the serial update channel and the 8-lane update consumers, and emits partial groups on an explicit flush or when the input goes idle.

## Interface
- WIDTH, 64, update word width
- LANES, 8, lanes per group; power of two, 2..16
- TIMEOUT, 16, idle cycles with a partial group before a forced emit; 1..255
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- input_word  in  WIDTH  serial update
- input_valid  in  1  input_word is valid this cycle
- flush  in  1  end-of-partition; close the current group
- downstream_stall  in  1  consumer cannot take a group this cycle
- output_update0..output_update7  out  WIDTH each  lane i of the emitted group
- output_valid0..output_valid7  out  1 each  lane i valid; single-cycle pulse
- gather_stall_request  out  1  source must hold input_word; the word is not accepted

## Operation
- State:
  - buf[0..LANES-1]
  - cnt (0..LANES)
  - flush_pend
  - idle timer
- Accept:
  - A word is accepted when input_valid=1 and gather_stall_request=0.
  - It is written to buf[cnt], and cnt increments.
- gather_stall_request = (cnt==LANES or flush_pend) and downstream_stall.
  - It is combinational from registered state plus downstream_stall.
- Emit condition, evaluated on registered state:
  - (cnt==LANES or flush_pend) and cnt>0 and downstream_stall=0.
- On emit:
  - output_update_i <= buf[i].
  - output_valid_i <= (i < cnt).
  - cnt <= 0, flush_pend <= 0, timer <= 0.
- Simultaneous emit and accept: the accepted word goes to buf[0], and cnt <= 1.
- No emit: all output_valid_i <= 0 next cycle. output_update_i holds its last emitted value.
- Packing order: the first accepted word lands in lane 0. Valid lanes are always contiguous from lane 0.
- flush:
  - Sets flush_pend when (cnt>0) or a word is accepted in the same cycle.
  - A word accepted in the flush cycle belongs to the flushed group.
  - flush with an empty buffer and no accepted word is ignored.
  - flush while flush_pend=1 has no extra effect.
- Idle timer:
  - Increments each cycle that cnt>0, nothing is accepted, and flush_pend=0.
  - Clears on accept or emit.
  - On reaching TIMEOUT it sets flush_pend, then clears.
- Once flush_pend is set, further input is accepted only in the emit cycle, when it goes to the next group. While flush_pend=1 and downstream_stall=1, gather_stall_request is asserted.
- Full with no stall: the group is emitted and a new word is accepted in the same cycle, so there is no bubble.
- Reset:
  - All output_update_i = 0, output_valid_i = 0, gather_stall_request = 0 (combinationally, since state is clear).
  - cnt, flush_pend and the timer are cleared.
  - A partial group in progress is dropped without emission.

## Timing
- Latency: the group-completing word is sampled at edge E. output_valid_* are visible after edge E+1 when downstream_stall=0 during cycle E..E+1.
- Flush latency: flush sampled at edge E gives an emit after edge E+1, or later if stalled.
- Timeout: the last accept at edge E with no further input gives an emit after edge E+TIMEOUT+1.
- Sustained throughput: one word per cycle and one group per LANES cycles, with no stall request while downstream_stall=0.
- gather_stall_request can only assert in cycles where downstream_stall=1.

## Structure
- The shared package se_pkg holds:
  - UPDATE_W=64 and SE_LANES=8, shared with the serializer.
  - The lane-index and count widths ($clog2(LANES), $clog2(LANES+1)).
- One sub-module, gather_idle_timer:
  - Inputs: clk, rst, run, clear.
  - Output: expired, asserted for one cycle on reaching TIMEOUT.
- Everything else is a single always block for buf/cnt/flush_pend/outputs, plus the combinational stall equation.

## Test plan
- Back-to-back, no stall: 8 words 0x1..0x8 accepted at edges 1..8.
  - Expected: output_update0..7 = 0x1..0x8 and all valids high for exactly one cycle after edge 9.
  - Expected: gather_stall_request never asserts.
- Partial flush: words 0xA, 0xB, 0xC, then flush.
  - Expected: lanes 0..2 = 0xA, 0xB, 0xC valid; valid3..7 = 0; a single pulse.
- Timeout, TIMEOUT=4: 2 words, then idle.
  - Expected: emit 5 cycles after the last accept edge, with lanes 0..1 valid.
- Downstream backpressure: 8 words, then downstream_stall held 5 cycles while the 9th word (0x9) is presented.
  - Expected: gather_stall_request high for those 5 cycles.
  - Expected: group 0x1..0x8 emitted when the stall drops, with 0x9 accepted into lane 0 of the next group in the same cycle.
- Continuous stream: 16 words with no gaps.
  - Expected: two groups emitted 8 cycles apart, contents in order, no stall request.
- Reset mid-group: 5 words accepted, then rst for 1 cycle, then 8 new words 0x10..0x17.
  - Expected: no emission of the 5 dropped words; the next group is 0x10..0x17 in lanes 0..7.
